// File: rtl/keycode_voice_allocator.sv
// keycode_voice_allocator
// Turns changes on the keycode register into note-off / note-on events for
// the voice bank. It also tracks which voices are gated, which are in their
// release tail, and which are free.
module keycode_voice_allocator #(
    parameter int NUM_VOICES  = 4,
    parameter int RELEASE_LEN = 50000,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            keycode,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic                  evt_on,
    output logic [2:0]            evt_voice,
    output logic [7:0]            evt_key,
    output logic [NUM_VOICES-1:0] voice_gate,
    output logic [NUM_VOICES-1:0] voice_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFF_EVT = 2'd1,
        ALLOC   = 2'd2,
        ON_EVT  = 2'd3
    } state_t;

    state_t           state;
    logic [7:0]       cur_key;
    logic [2:0]       cur_voice;

    logic [NUM_VOICES-1:0] gate_q;
    logic [NUM_VOICES-1:0] rel_q;
    logic [7:0]            vkey_q [NUM_VOICES];
    logic [CNT_W-1:0]      cnt_q  [NUM_VOICES];

    logic             off_accept;
    logic             on_accept;
    logic             alloc_take;
    logic             found_match;
    logic             found_free;
    logic             found_rel;
    logic [2:0]       match_idx;
    logic [2:0]       free_idx;
    logic [2:0]       steal_idx;
    logic [CNT_W-1:0] best_cnt;
    logic [2:0]       alloc_voice;

    assign off_accept = (state == OFF_EVT) && evt_valid && evt_ready;
    assign on_accept  = (state == ON_EVT)  && evt_valid && evt_ready;
    assign alloc_take = (state == ALLOC)   && (keycode != 8'd0);

    assign voice_gate = gate_q;
    assign voice_busy = gate_q | rel_q;

    // Pick a voice for the key: retrigger its own tail first, then the lowest free voice, then steal the shortest tail
    always_comb begin
        found_match = 1'b0;
        found_free  = 1'b0;
        found_rel   = 1'b0;
        match_idx   = 3'd0;
        free_idx    = 3'd0;
        steal_idx   = 3'd0;
        best_cnt    = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (rel_q[i] && (vkey_q[i] == keycode) && !found_match) begin
                found_match = 1'b1;
                match_idx   = 3'(i);
            end
            if (!rel_q[i] && !gate_q[i] && !found_free) begin
                found_free = 1'b1;
                free_idx   = 3'(i);
            end
            if (rel_q[i] && (!found_rel || (cnt_q[i] < best_cnt))) begin
                found_rel = 1'b1;
                steal_idx = 3'(i);
                best_cnt  = cnt_q[i];
            end
        end
        if (found_match) begin
            alloc_voice = match_idx;
        end else if (found_free) begin
            alloc_voice = free_idx;
        end else if (found_rel) begin
            alloc_voice = steal_idx;
        end else begin
            alloc_voice = 3'd0;
        end
    end

    // Event sequencer: compares keycode against the held key and offers registered off/on events
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_key   <= 8'd0;
            cur_voice <= 3'd0;
            evt_valid <= 1'b0;
            evt_on    <= 1'b0;
            evt_voice <= 3'd0;
            evt_key   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (keycode != cur_key) begin
                        if (cur_key != 8'd0) begin
                            state     <= OFF_EVT;
                            evt_valid <= 1'b1;
                            evt_on    <= 1'b0;
                            evt_voice <= cur_voice;
                            evt_key   <= cur_key;
                        end else begin
                            state <= ALLOC;
                        end
                    end
                end
                OFF_EVT: begin
                    if (evt_valid && evt_ready) begin
                        evt_valid <= 1'b0;
                        cur_key   <= 8'd0;
                        state     <= (keycode != 8'd0) ? ALLOC : IDLE;
                    end
                end
                ALLOC: begin
                    if (keycode == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        cur_key   <= keycode;
                        cur_voice <= alloc_voice;
                        evt_valid <= 1'b1;
                        evt_on    <= 1'b1;
                        evt_voice <= alloc_voice;
                        evt_key   <= keycode;
                        state     <= ON_EVT;
                    end
                end
                ON_EVT: begin
                    if (evt_valid && evt_ready) begin
                        evt_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-voice state: allocation, gate/release on accepted events, and the free-running release tails
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_q <= '0;
            rel_q  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vkey_q[i] <= 8'd0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (alloc_take && (alloc_voice == 3'(i))) begin
                    vkey_q[i] <= keycode;
                    cnt_q[i]  <= '0;
                end else if (off_accept && (cur_voice == 3'(i))) begin
                    gate_q[i] <= 1'b0;
                    rel_q[i]  <= 1'b1;
                    cnt_q[i]  <= CNT_W'(RELEASE_LEN);
                end else if (on_accept && (cur_voice == 3'(i))) begin
                    gate_q[i] <= 1'b1;
                    rel_q[i]  <= 1'b0;
                end else if (rel_q[i] && (cnt_q[i] != '0)) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                    if (cnt_q[i] == CNT_W'(1)) begin
                        rel_q[i]  <= 1'b0;
                        vkey_q[i] <= 8'd0;
                    end
                end
            end
        end
    end

endmodule
